uart_rx: RTL

UART receiver: deserialises an asynchronous 8N1-style serial line into parallel bytes using the 16x oversampling tick produced by `baudrate_gen`. It is the consumer of that tick, sitting between the external RX pin and the downstream byte interface. Each received frame yields a one-cycle `o_rx_done` strobe with the data byte and frame-error status.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/sync_2ff.sv | 28 ++
 rtl/uart_rx.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, oversampling constants and a
// constant-evaluable ceil(log2) helper also used by baudrate_gen.
package uart_pkg;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned MID_TICK   = 7;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } rx_state_e;

    // ceil(log2(value)); returns 0 for value <= 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser for asynchronous inputs. RESET_VAL sets the
// value both flops take while reset is asserted (idle level of the line).
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops give the first one a full cycle to resolve.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start + DBIT data bits (LSB first) [+ parity] + stop, using a
// 16x oversampling tick. Define UART_RX_PARITY_EN to add a parity bit between
// the data bits and the stop bit; without it o_parity_err is tied to 0.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DBIT       = 8,
    parameter int unsigned SB_TICK    = 16,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_tick,
    input  logic            i_rx,
    output logic [DBIT-1:0] o_data,
    output logic            o_rx_done,
    output logic            o_frame_err,
    output logic            o_parity_err
);

    // Tick counter must reach SB_TICK-1, which exceeds 15 for 1.5/2 stop bits.
    localparam int unsigned SW = (clog2(SB_TICK) > 4) ? clog2(SB_TICK) : 4;
    localparam int unsigned NW = (clog2(DBIT) > 1) ? clog2(DBIT) : 1;

    localparam logic [SW-1:0] S_MID  = SW'(MID_TICK);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

    if (DBIT < 5 || DBIT > 9) begin : g_bad_dbit
        $error("uart_rx: DBIT must be 5..9");
    end
    if (PARITY_ODD > 1) begin : g_bad_parity
        $error("uart_rx: PARITY_ODD must be 0 or 1");
    end
    if (SB_TICK < 1) begin : g_bad_sb_tick
        $error("uart_rx: SB_TICK must be at least 1");
    end

    logic            rx_s;
    rx_state_e       state_q, state_d;
    logic [SW-1:0]   s_cnt_q, s_cnt_d;
    logic [NW-1:0]   n_cnt_q, n_cnt_d;
    logic [DBIT-1:0] b_reg_q, b_reg_d;
    logic [DBIT-1:0] data_q, data_d;
    logic            done_q, done_d;
    logic            frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
    logic            parity_bit_q, parity_bit_d;
    logic            parity_err_q, parity_err_d;
`endif

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync_rx (
        .clk (i_clk),
        .rst (i_reset),
        .d   (i_rx),
        .q   (rx_s)
    );

    // State, counters, shift register and registered outputs.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= StIdle;
            s_cnt_q      <= '0;
            n_cnt_q      <= '0;
            b_reg_q      <= '0;
            data_q       <= '0;
            done_q       <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bit_q <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            s_cnt_q      <= s_cnt_d;
            n_cnt_q      <= n_cnt_d;
            b_reg_q      <= b_reg_d;
            data_q       <= data_d;
            done_q       <= done_d;
            frame_err_q  <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            parity_bit_q <= parity_bit_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    // Next-state logic; s_cnt is cleared on every state transition.
    always_comb begin
        state_d      = state_q;
        s_cnt_d      = s_cnt_q;
        n_cnt_d      = n_cnt_q;
        b_reg_d      = b_reg_q;
        data_d       = data_q;
        done_d       = 1'b0;
        frame_err_d  = frame_err_q;
`ifdef UART_RX_PARITY_EN
        parity_bit_d = parity_bit_q;
        parity_err_d = parity_err_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (!rx_s) begin
                    state_d = StStart;
                    s_cnt_d = '0;
                end
            end
            StStart: begin
                if (i_tick) begin
                    if (s_cnt_q == S_MID) begin
                        // Line must still be low at the start-bit centre.
                        state_d = rx_s ? StIdle : StData;
                        s_cnt_d = '0;
                        n_cnt_d = '0;
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
            end
            StData: begin
                if (i_tick) begin
                    if (s_cnt_q == S_LAST) begin
                        s_cnt_d = '0;
                        b_reg_d = {rx_s, b_reg_q[DBIT-1:1]};
                        if (n_cnt_q == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = StParity;
`else
                            state_d = StStop;
`endif
                        end else begin
                            n_cnt_d = n_cnt_q + 1'b1;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
            end
            StParity: begin
`ifdef UART_RX_PARITY_EN
                if (i_tick) begin
                    if (s_cnt_q == S_LAST) begin
                        parity_bit_d = rx_s;
                        state_d      = StStop;
                        s_cnt_d      = '0;
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
`else
                state_d = StIdle;
                s_cnt_d = '0;
`endif
            end
            StStop: begin
                if (i_tick) begin
                    if (s_cnt_q == S_STOP) begin
                        state_d      = StIdle;
                        s_cnt_d      = '0;
                        data_d       = b_reg_q;
                        frame_err_d  = ~rx_s;
                        done_d       = 1'b1;
`ifdef UART_RX_PARITY_EN
                        parity_err_d = ((^b_reg_q) ^ parity_bit_q) != PARITY_ODD[0];
`endif
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                s_cnt_d = '0;
            end
        endcase
    end

    assign o_data      = data_q;
    assign o_rx_done   = done_q;
    assign o_frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
    assign o_parity_err = parity_err_q;
`else
    assign o_parity_err = 1'b0;
`endif

endmodule
